// File: rtl/router_pkg.sv
// Shared router types and header field layout, used by the ingress FIFOs and router_arbiter.
package router_pkg;

    localparam int unsigned ROUTER_DATA_W = 64;

    localparam int unsigned DEST_ADDR_LSB = 0;
    localparam int unsigned DEST_ADDR_W   = 10;
    localparam int unsigned DEST_FPGA_LSB = 10;
    localparam int unsigned DEST_FPGA_W   = 2;
    localparam int unsigned SRC_ADDR_LSB  = 12;
    localparam int unsigned SRC_ADDR_W    = 10;
    localparam int unsigned HDR_RSVD_W    = ROUTER_DATA_W - SRC_ADDR_LSB - SRC_ADDR_W;

    typedef struct packed {
        logic [HDR_RSVD_W-1:0]  rsvd;
        logic [SRC_ADDR_W-1:0]  src_addr;
        logic [DEST_FPGA_W-1:0] dest_fpga;
        logic [DEST_ADDR_W-1:0] dest_addr;
    } hdr_t;

    typedef struct packed {
        logic                     last;
        logic [ROUTER_DATA_W-1:0] data;
    } beat_t;

endpackage

// File: rtl/router_fifo_mem.sv
// Beat storage for the ingress FIFO: one synchronous write port, asynchronous read, array not reset.
module router_fifo_mem
    import router_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  beat_t             wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output beat_t             rdata_o
);

    beat_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/router_ingress_fifo.sv
// Per-port ingress packet FIFO with head-of-queue header decode for the router arbiter.
// Define ROUTER_STORE_FWD_EN for store-and-forward; otherwise the FIFO is cut-through.
module router_ingress_fifo
    import router_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ROUTER_DATA_W-1:0] s_tdata,
    input  logic                     s_tvalid,
    output logic                     s_tready,
    input  logic                     s_tlast,
    output logic [ROUTER_DATA_W-1:0] m_tdata,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic                     m_tlast,
    output logic                     hdr_valid,
    output logic [DEST_ADDR_W-1:0]   hdr_dest_addr,
    output logic [DEST_FPGA_W-1:0]   hdr_dest_fpga,
    output logic [SRC_ADDR_W-1:0]    hdr_src_addr,
    output logic [ADDR_W:0]          pkt_count,
    output logic                     err_oversize
);

    localparam int unsigned PTR_W = ADDR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] pkt_count_q, pkt_count_d;
    logic             sop_q, sop_d;
    logic             full, empty, wr_en, rd_en, head_valid;
    beat_t            wr_beat, rd_beat;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                   (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);

`ifdef ROUTER_STORE_FWD_EN
    logic release_q, release_d;
    logic err_q, err_d;

    // A packet that fills the FIFO without its tlast can never complete, so let it drain cut-through.
    assign head_valid = !empty && ((pkt_count_q != '0) || release_q);

    always_comb begin
        release_d = release_q;
        err_d     = err_q;
        if (full && (pkt_count_q == '0)) begin
            release_d = 1'b1;
            err_d     = 1'b1;
        end else if (rd_en && rd_beat.last) begin
            release_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            release_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            release_q <= release_d;
            err_q     <= err_d;
        end
    end

    assign err_oversize = err_q;
`else
    assign head_valid   = !empty;
    assign err_oversize = 1'b0;
`endif

    assign s_tready = !full;
    assign wr_en    = s_tvalid && !full;
    assign rd_en    = head_valid && m_tready;

    assign wr_beat.last = s_tlast;
    assign wr_beat.data = s_tdata;

    assign m_tvalid  = head_valid;
    assign m_tdata   = head_valid ? rd_beat.data : '0;
    assign m_tlast   = head_valid && rd_beat.last;
    assign hdr_valid = head_valid && sop_q;

    assign hdr_dest_addr = hdr_valid ? m_tdata[DEST_ADDR_LSB +: DEST_ADDR_W] : '0;
    assign hdr_dest_fpga = hdr_valid ? m_tdata[DEST_FPGA_LSB +: DEST_FPGA_W] : '0;
    assign hdr_src_addr  = hdr_valid ? m_tdata[SRC_ADDR_LSB +: SRC_ADDR_W]   : '0;
    assign pkt_count     = pkt_count_q;

    // Pointer, start-of-packet and packet-count next state.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        sop_d       = sop_q;
        pkt_count_d = pkt_count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            sop_d    = rd_beat.last;
        end
        case ({wr_en && s_tlast, rd_en && rd_beat.last})
            2'b10:   pkt_count_d = pkt_count_q + PTR_W'(1);
            2'b01:   pkt_count_d = pkt_count_q - PTR_W'(1);
            default: pkt_count_d = pkt_count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            sop_q       <= 1'b1;
            pkt_count_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            sop_q       <= sop_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    router_fifo_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q[ADDR_W-1:0]),
        .wdata_i (wr_beat),
        .raddr_i (rd_ptr_q[ADDR_W-1:0]),
        .rdata_o (rd_beat)
    );

endmodule
